// File: rtl/spi_slave_receiver_if.sv
// SPI slave receiver bus: external SPI pins plus the byte/pixel strobes
// delivered to the output controller and the pixel buffer.
//
// Handshake semantics: there is no backpressure anywhere on this bus. Each
// strobe (shift_SPI, byte_ready, pixel_wr, image_done, cmd_error) is a
// valid-only pulse exactly one clk wide. The consumer must take it in that
// cycle. Its qualifying data (SPI_in for byte_ready, pixel_addr/pixel_data
// for pixel_wr) is stable for the whole cycle in which the strobe is high.
interface spi_slave_receiver_if #(
    parameter int ADDR_W = 10
);
    logic              SCK;
    logic              SS;
    logic              MOSI;
    logic              shift_SPI;
    logic [7:0]        SPI_in;
    logic              byte_ready;
    logic              pixel_wr;
    logic [ADDR_W-1:0] pixel_addr;
    logic [7:0]        pixel_data;
    logic              image_done;
    logic              cmd_error;

    // Receiver side: samples the pins, drives the strobes
    modport slave (
        input  SCK, SS, MOSI,
        output shift_SPI, SPI_in, byte_ready, pixel_wr, pixel_addr,
               pixel_data, image_done, cmd_error
    );

    // SPI master / environment side
    modport master (
        output SCK, SS, MOSI,
        input  shift_SPI, SPI_in, byte_ready, pixel_wr, pixel_addr,
               pixel_data, image_done, cmd_error
    );
endinterface

// File: rtl/spi_slave_receiver.sv
// SPI slave front end (mode 0, MSB first). Synchronizes the async pins,
// assembles bytes, decodes the first byte of each SS-low frame as a command
// and streams image-load bytes into the pixel buffer.
module spi_slave_receiver #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10
) (
    input  logic                   clk,
    input  logic                   n_rst,
    spi_slave_receiver_if.slave    bus,
    output logic [2:0]             fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        COST   = 3'd2,
        LOAD   = 3'd3,
        IGNORE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [7:0]        CMD_COST  = 8'h01;
    localparam logic [7:0]        CMD_LOAD  = 8'h02;

    // Pin synchronizers and edge-detect registers
    logic sck_meta, sck_sync, sck_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic mosi_meta, mosi_sync;

    logic sck_rise, sck_fall, ss_fall, ss_rise;

    // Byte assembly
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       byte_pending;
    logic       byte_fire;
    logic [7:0] spi_in_q;
    logic       byte_ready_q;
    logic       shift_spi_q;

    // Command FSM and pixel write path
    state_t            state, state_d;
    logic              pixel_wr_q, wr_d;
    logic [ADDR_W-1:0] pixel_addr_q;
    logic [7:0]        pixel_data_q;
    logic              image_done_q, done_d;
    logic              cmd_error_q, err_d;
    logic              addr_clr, addr_inc;

    // Two-FF synchronizers plus one history stage on SCK and SS; SS idles high
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= bus.SCK;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            ss_meta   <= bus.SS;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            mosi_meta <= bus.MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    assign sck_rise = sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync & sck_prev;
    assign ss_fall  = ~ss_sync & ss_prev;
    assign ss_rise  = ss_sync & ~ss_prev;

    // A completed byte is delivered one cycle after the 8th rising edge,
    // unless SS rises in that same cycle, in which case the byte is dropped.
    assign byte_fire = byte_pending & ~ss_rise;

    // Shift MOSI on SCK rise, count bits, publish completed bytes to SPI_in
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg    <= 8'h00;
            bit_cnt      <= 3'd0;
            byte_pending <= 1'b0;
            spi_in_q     <= 8'h00;
            byte_ready_q <= 1'b0;
            shift_spi_q  <= 1'b0;
        end else begin
            shift_spi_q  <= sck_fall & ~ss_sync;
            byte_pending <= 1'b0;
            byte_ready_q <= 1'b0;
            if (ss_rise) begin
                // End of frame: drop any partial byte and clear SPI_in so the
                // downstream controller never sees a stale command byte.
                bit_cnt   <= 3'd0;
                shift_reg <= 8'h00;
                spi_in_q  <= 8'h00;
            end else begin
                if (sck_rise && !ss_sync) begin
                    shift_reg    <= {shift_reg[6:0], mosi_sync};
                    bit_cnt      <= bit_cnt + 3'd1;
                    byte_pending <= (bit_cnt == 3'd7);
                end
                if (byte_pending) begin
                    spi_in_q     <= shift_reg;
                    byte_ready_q <= 1'b1;
                end
            end
        end
    end

    // FSM state register and registered strobes / pixel write port
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            pixel_wr_q   <= 1'b0;
            pixel_addr_q <= '0;
            pixel_data_q <= 8'h00;
            image_done_q <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            state        <= state_d;
            pixel_wr_q   <= wr_d;
            image_done_q <= done_d;
            cmd_error_q  <= err_d;
            if (wr_d) begin
                pixel_data_q <= shift_reg;
            end
            if (addr_clr) begin
                pixel_addr_q <= '0;
            end else if (addr_inc) begin
                pixel_addr_q <= pixel_addr_q + ADDR_ONE;
            end
        end
    end

    // Next-state and strobe decode; SS rising edge returns to IDLE from anywhere
    always_comb begin
        state_d  = state;
        wr_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        addr_clr = 1'b0;
        addr_inc = 1'b0;
        if (ss_rise) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (byte_fire) begin
                        if (shift_reg == CMD_COST) begin
                            state_d = COST;
                        end else if (shift_reg == CMD_LOAD) begin
                            addr_clr = 1'b1;
                            state_d  = LOAD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IGNORE;
                        end
                    end
                end
                LOAD: begin
                    if (byte_fire) begin
                        wr_d = 1'b1;
                    end
                    // Advance the address in the write cycle itself so the
                    // write sees the current index; the last write holds it.
                    if (pixel_wr_q) begin
                        if (pixel_addr_q == LAST_ADDR) begin
                            done_d  = 1'b1;
                            state_d = IGNORE;
                        end else begin
                            addr_inc = 1'b1;
                        end
                    end
                end
                COST:    state_d = state;
                IGNORE:  state_d = state;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.shift_SPI  = shift_spi_q;
    assign bus.SPI_in     = spi_in_q;
    assign bus.byte_ready = byte_ready_q;
    assign bus.pixel_wr   = pixel_wr_q;
    assign bus.pixel_addr = pixel_addr_q;
    assign bus.pixel_data = pixel_data_q;
    assign bus.image_done = image_done_q;
    assign bus.cmd_error  = cmd_error_q;
    assign fsm_state      = state;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Directed bench for spi_slave_receiver: reset, cost command, image load,
// mid-byte abort, bad command and reset during a load.
module tb_spi_slave_receiver;

    localparam int ADDR_W = 10;
    // Image size kept above 256 so pixel data wraps, but short enough that
    // two complete loads fit comfortably in the run.
    localparam int N_PIX  = 300;
    localparam int HALF   = 4;   // SCK half period in clk cycles

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_COST   = 3'd2;
    localparam logic [2:0] ST_IGNORE = 3'd4;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);

    logic       clk;
    logic       n_rst;
    logic [2:0] fsm_state;

    spi_slave_receiver_if #(.ADDR_W(ADDR_W)) bus ();

    spi_slave_receiver #(
        .NUM_PIXELS(N_PIX),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .bus      (bus),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int tests_run = 0;
    int tests_failed = 0;

    logic [ADDR_W+7:0] exp_q[$];   // {addr, data} of each expected pixel write

    int              n_shift = 0;
    int              n_br    = 0;
    int              n_wr    = 0;
    int              n_done  = 0;
    int              n_err   = 0;
    logic [7:0]      last_byte = 8'h00;
    logic            prev_wr   = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: sampled on the falling clk edge, away from the active edge
    always @(negedge clk) begin
        logic [ADDR_W+7:0] e;
        if (bus.shift_SPI) n_shift++;
        if (bus.byte_ready) begin
            n_br++;
            last_byte = bus.SPI_in;
        end
        if (bus.cmd_error) begin
            n_err++;
            check("err_in_br_cycle", {23'd0, bus.byte_ready, bus.SPI_in}, {23'd0, 1'b1, 8'h7F});
        end
        if (bus.image_done) begin
            n_done++;
            check("done_after_last", {21'd0, prev_wr, prev_addr}, {21'd0, 1'b1, LAST});
        end
        if (bus.pixel_wr) begin
            n_wr++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check("pixel_write", {14'd0, bus.pixel_addr, bus.pixel_data}, {14'd0, e});
        end
        prev_wr   = bus.pixel_wr;
        prev_addr = bus.pixel_addr;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bus.MOSI = b[i];
            wait_clk(HALF);
            bus.SCK = 1'b1;
            wait_clk(HALF);
            bus.SCK = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.MOSI = b[i];
            wait_clk(HALF);
            bus.SCK = 1'b1;
            wait_clk(HALF);
            bus.SCK = 1'b0;
        end
    endtask

    task automatic ss_low();
        bus.SS = 1'b0;
        wait_clk(6);
    endtask

    task automatic ss_high();
        wait_clk(6);
        bus.SS = 1'b1;
        wait_clk(10);
    endtask

    task automatic expect_load(input int count);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back({ADDR_W'(i), 8'(i % 256)});
        end
    endtask

    task automatic send_load(input int count);
        for (int i = 0; i < count; i++) begin
            send_byte(8'(i % 256));
        end
    endtask

    // ---------------- stimulus ----------------
    int b_shift, b_br, b_wr, b_done, b_err;

    task automatic snap();
        b_shift = n_shift;
        b_br    = n_br;
        b_wr    = n_wr;
        b_done  = n_done;
        b_err   = n_err;
    endtask

    initial begin
        n_rst    = 1'b0;
        bus.SCK  = 1'b0;
        bus.SS   = 1'b1;
        bus.MOSI = 1'b0;

        // Reset held with SCK toggling and SS low
        bus.SS = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_clk(HALF);
            bus.SCK = ~bus.SCK;
            bus.MOSI = ~bus.MOSI;
        end
        check("rst_SPI_in",     {24'd0, bus.SPI_in},     32'h00);
        check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'h0);
        check("rst_shift_SPI",  {31'd0, bus.shift_SPI},  32'h0);
        check("rst_pixel_wr",   {31'd0, bus.pixel_wr},   32'h0);
        check("rst_pixel_addr", {22'd0, bus.pixel_addr}, 32'h0);
        check("rst_pixel_data", {24'd0, bus.pixel_data}, 32'h00);
        check("rst_image_done", {31'd0, bus.image_done}, 32'h0);
        check("rst_cmd_error",  {31'd0, bus.cmd_error},  32'h0);
        check("rst_fsm",        {29'd0, fsm_state},      {29'd0, ST_IDLE});

        // Release with SS high and SCK still toggling: nothing may happen
        bus.SS  = 1'b1;
        bus.SCK = 1'b0;
        wait_clk(3);
        n_rst = 1'b1;
        wait_clk(3);
        snap();
        for (int i = 0; i < 8; i++) begin
            wait_clk(HALF);
            bus.SCK = ~bus.SCK;
        end
        wait_clk(6);
        check("ss_high_no_shift", n_shift - b_shift, 0);
        check("ss_high_no_byte",  n_br - b_br,       0);
        check("ss_high_fsm",      {29'd0, fsm_state}, {29'd0, ST_IDLE});

        // Cost command
        snap();
        ss_low();
        send_byte(8'h01);
        wait_clk(6);
        check("cost_shift_cnt", n_shift - b_shift, 8);
        check("cost_br_cnt",    n_br - b_br,       1);
        check("cost_byte",      {24'd0, last_byte},  32'h01);
        check("cost_SPI_in",    {24'd0, bus.SPI_in}, 32'h01);
        check("cost_fsm",       {29'd0, fsm_state},  {29'd0, ST_COST});
        bus.SS = 1'b1;
        wait_clk(4);
        check("cost_SPI_in_clr", {24'd0, bus.SPI_in}, 32'h00);
        wait_clk(10);
        check("cost_no_wr",     n_wr - b_wr,       0);
        check("cost_fsm_idle",  {29'd0, fsm_state}, {29'd0, ST_IDLE});

        // Image load with three trailing bytes
        snap();
        ss_low();
        send_byte(8'h02);
        expect_load(N_PIX);
        send_load(N_PIX);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'hC3);
        wait_clk(6);
        check("load_wr_cnt",   n_wr - b_wr,     N_PIX);
        check("load_q_empty",  exp_q.size(),    0);
        check("load_done_cnt", n_done - b_done, 1);
        check("load_br_cnt",   n_br - b_br,     N_PIX + 4);
        check("load_addr_hold", {22'd0, bus.pixel_addr}, {22'd0, LAST});
        check("load_SPI_in",   {24'd0, bus.SPI_in},      32'hC3);
        check("load_fsm",      {29'd0, fsm_state},       {29'd0, ST_IGNORE});
        ss_high();
        check("load_err_cnt",  n_err - b_err,   0);

        // Abort mid-byte, then a clean cost command
        snap();
        ss_low();
        send_bits(8'hFF, 5);
        ss_high();
        check("abort_no_byte", n_br - b_br, 0);
        check("abort_shift",   n_shift - b_shift, 5);
        ss_low();
        send_byte(8'h01);
        wait_clk(6);
        check("abort_next_br",   n_br - b_br, 1);
        check("abort_next_byte", {24'd0, last_byte}, 32'h01);
        check("abort_next_fsm",  {29'd0, fsm_state}, {29'd0, ST_COST});
        ss_high();

        // Bad command followed by 0x02
        snap();
        ss_low();
        send_byte(8'h7F);
        send_byte(8'h02);
        wait_clk(6);
        check("bad_err_cnt", n_err - b_err, 1);
        check("bad_br_cnt",  n_br - b_br,   2);
        check("bad_no_wr",   n_wr - b_wr,   0);
        check("bad_fsm",     {29'd0, fsm_state}, {29'd0, ST_IGNORE});
        ss_high();

        // Reset in the middle of a load, then a full load
        snap();
        ss_low();
        send_byte(8'h02);
        expect_load(100);
        send_load(100);
        wait_clk(4);
        check("midrst_wr_cnt", n_wr - b_wr, 100);
        check("midrst_q_empty", exp_q.size(), 0);
        n_rst = 1'b0;
        wait_clk(2);
        check("midrst_addr", {22'd0, bus.pixel_addr}, 32'h0);
        check("midrst_fsm",  {29'd0, fsm_state}, {29'd0, ST_IDLE});
        bus.SS = 1'b1;
        wait_clk(3);
        n_rst = 1'b1;
        wait_clk(10);
        snap();
        ss_low();
        send_byte(8'h02);
        expect_load(N_PIX);
        send_load(N_PIX);
        wait_clk(6);
        check("reload_wr_cnt",   n_wr - b_wr,     N_PIX);
        check("reload_q_empty",  exp_q.size(),    0);
        check("reload_done_cnt", n_done - b_done, 1);
        ss_high();
        check("reload_err_cnt",  n_err - b_err,   0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
